// File: rtl/kmer_count_query.sv
// Count-min sketch read port: hashes a k-mer like the LFSR writer, reads the
// shared row from four counter SRAMs and returns the minimum counter plus a solid flag.
module kmer_count_query #(
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned SOLID_THRESHOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        q_valid,
    output logic        q_ready,
    input  logic [97:0] q_kmer,
    output logic [6:0]  address,
    output logic        CSB,
    output logic        OEB,
    output logic        WEB,
    input  logic [63:0] dataout1,
    input  logic [63:0] dataout2,
    input  logic [63:0] dataout3,
    input  logic [63:0] dataout4,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [1:0]  r_count,
    output logic        r_solid,
    output logic [7:0]  r_position,
    output logic        busy
);

    localparam int unsigned ROW_W = 7;
    localparam int unsigned OFF_W = 6;
    localparam int unsigned LAT_W = 3;
    localparam int unsigned POS_W = 8;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   address_q, address_d;
    logic [OFF_W-1:0]   off1_q, off1_d, off2_q, off2_d, off3_q, off3_d, off4_q, off4_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [LAT_W-1:0]   wait_q, wait_d;
    logic               csb_q, csb_d;
    logic               q_ready_q, q_ready_d;
    logic               busy_q, busy_d;
    logic               r_valid_q, r_valid_d;
    logic [CNT_W-1:0]   r_count_q, r_count_d;
    logic               r_solid_q, r_solid_d;
    logic [POS_W-1:0]   r_position_q, r_position_d;

    logic [79:0]        taps_c;
    logic [ROW_W-1:0]   row_c;
    logic [OFF_W-1:0]   off1_c, off2_c, off3_c, off4_c;
    logic [CNT_W-1:0]   min_c;
    logic               unused_kmer_bits;

    // Bits between the position field and the k-mer carry nothing for the hash.
    assign unused_kmer_bits = ^q_kmer[89:80];

    function automatic logic [CNT_W-1:0] min2(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Writer-compatible hash: adjacent-bit XOR taps feed row and counter offsets.
    always_comb begin
        taps_c = q_kmer[79:0] ^ {q_kmer[78:0], 1'b0};
        row_c  = {taps_c[5], taps_c[20], taps_c[45], taps_c[67], taps_c[17], taps_c[72], taps_c[36]};
        off1_c = {taps_c[15], taps_c[51], taps_c[25], taps_c[50], taps_c[31], 1'b0};
        off2_c = {taps_c[9],  taps_c[44], taps_c[58], taps_c[13], taps_c[66], 1'b0};
        off3_c = {taps_c[40], taps_c[24], taps_c[55], taps_c[20], taps_c[60], 1'b0};
        off4_c = {taps_c[15], taps_c[30], taps_c[5],  taps_c[61], taps_c[45], 1'b0};
    end

    always_comb begin
        min_c = min2(min2(dataout1[off1_q +: 2], dataout2[off2_q +: 2]),
                     min2(dataout3[off3_q +: 2], dataout4[off4_q +: 2]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            off1_q       <= '0;
            off2_q       <= '0;
            off3_q       <= '0;
            off4_q       <= '0;
            pos_q        <= '0;
            wait_q       <= '0;
            csb_q        <= 1'b1;
            q_ready_q    <= 1'b1;
            busy_q       <= 1'b0;
            r_valid_q    <= 1'b0;
            r_count_q    <= '0;
            r_solid_q    <= 1'b0;
            r_position_q <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            off1_q       <= off1_d;
            off2_q       <= off2_d;
            off3_q       <= off3_d;
            off4_q       <= off4_d;
            pos_q        <= pos_d;
            wait_q       <= wait_d;
            csb_q        <= csb_d;
            q_ready_q    <= q_ready_d;
            busy_q       <= busy_d;
            r_valid_q    <= r_valid_d;
            r_count_q    <= r_count_d;
            r_solid_q    <= r_solid_d;
            r_position_q <= r_position_d;
        end
    end

    // Chip select is raised one edge ahead so it is low exactly during READ.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        off1_d       = off1_q;
        off2_d       = off2_q;
        off3_d       = off3_q;
        off4_d       = off4_q;
        pos_d        = pos_q;
        wait_d       = wait_q;
        csb_d        = 1'b1;
        r_valid_d    = r_valid_q;
        r_count_d    = r_count_q;
        r_solid_d    = r_solid_q;
        r_position_d = r_position_q;
        case (state_q)
            IDLE: begin
                if (q_valid && q_ready_q) begin
                    address_d = row_c;
                    off1_d    = off1_c;
                    off2_d    = off2_c;
                    off3_d    = off3_c;
                    off4_d    = off4_c;
                    pos_d     = q_kmer[97:90];
                    csb_d     = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                wait_d  = LAT_W'(READ_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    r_count_d    = min_c;
                    r_solid_d    = (min_c >= CNT_W'(SOLID_THRESHOLD));
                    r_position_d = pos_q;
                    r_valid_d    = 1'b1;
                    state_d      = RESULT;
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            RESULT: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        q_ready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    assign q_ready    = q_ready_q;
    assign busy       = busy_q;
    assign address    = address_q;
    assign CSB        = csb_q;
    assign OEB        = csb_q;
    assign WEB        = 1'b1;
    assign r_valid    = r_valid_q;
    assign r_count    = r_count_q;
    assign r_solid    = r_solid_q;
    assign r_position = r_position_q;

endmodule

// File: tb/tb_kmer_count_query.sv
// Directed bench for kmer_count_query: SRAM model with configurable read latency,
// scoreboard of hand-computed results checked by an independent monitor.
module tb_kmer_count_query;

    localparam int unsigned RL = 1;
    localparam int unsigned TH = 2;
    localparam logic [63:0] GARBAGE = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        q_valid;
    logic        q_ready;
    logic [97:0] q_kmer;
    logic [6:0]  address;
    logic        CSB, OEB, WEB;
    logic [63:0] dataout1, dataout2, dataout3, dataout4;
    logic        r_valid;
    logic        r_ready;
    logic [1:0]  r_count;
    logic        r_solid;
    logic [7:0]  r_position;
    logic        busy;

    typedef struct packed {
        logic [1:0] cnt;
        logic       solid;
        logic [7:0] pos;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    logic [63:0] mem1[128], mem2[128], mem3[128], mem4[128];
    logic [6:0]  a_pipe[RL];
    logic        v_pipe[RL];

    always #5 clk = ~clk;

    kmer_count_query #(.READ_LATENCY(RL), .SOLID_THRESHOLD(TH)) dut (
        .clk(clk), .reset(reset), .q_valid(q_valid), .q_ready(q_ready), .q_kmer(q_kmer),
        .address(address), .CSB(CSB), .OEB(OEB), .WEB(WEB),
        .dataout1(dataout1), .dataout2(dataout2), .dataout3(dataout3), .dataout4(dataout4),
        .r_valid(r_valid), .r_ready(r_ready), .r_count(r_count), .r_solid(r_solid),
        .r_position(r_position), .busy(busy)
    );

    // SRAM model: data appears RL edges after the edge that saw CSB/OEB low.
    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) begin
            a_pipe[i] <= a_pipe[i-1];
            v_pipe[i] <= v_pipe[i-1];
        end
        a_pipe[0] <= address;
        v_pipe[0] <= !reset && !CSB && !OEB;
    end

    assign dataout1 = v_pipe[RL-1] ? mem1[a_pipe[RL-1]] : GARBAGE;
    assign dataout2 = v_pipe[RL-1] ? mem2[a_pipe[RL-1]] : GARBAGE;
    assign dataout3 = v_pipe[RL-1] ? mem3[a_pipe[RL-1]] : GARBAGE;
    assign dataout4 = v_pipe[RL-1] ? mem4[a_pipe[RL-1]] : GARBAGE;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one compare per result handshake.
    always @(negedge clk) begin
        if (!reset && r_valid && r_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_result: got count %0d pos %0h, expected no result", r_count, r_position);
            end else begin
                mon_e = sb.pop_front();
                chk("r_count", 64'(r_count), 64'(mon_e.cnt));
                chk("r_solid", 64'(r_solid), 64'(mon_e.solid));
                chk("r_position", 64'(r_position), 64'(mon_e.pos));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!q_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!q_ready) chk("q_ready_timeout", 64'(q_ready), 64'd1);
    endtask

    task automatic send(input logic [97:0] k, input logic [6:0] ea, input logic [1:0] ec, input logic es);
        exp_t e;
        int   lat;
        wait_ready();
        e.cnt   = ec;
        e.solid = es;
        e.pos   = k[97:90];
        sb.push_back(e);
        q_kmer  = k;
        q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        lat = 1;
        chk("read_address", 64'(address), 64'(ea));
        chk("read_csb", 64'(CSB), 64'd0);
        chk("read_oeb", 64'(OEB), 64'd0);
        chk("read_busy", 64'(busy), 64'd1);
        chk("read_q_ready", 64'(q_ready), 64'd0);
        @(posedge clk); #1;
        lat = 2;
        chk("wait_csb", 64'(CSB), 64'd1);
        chk("wait_address", 64'(address), 64'(ea));
        while (!r_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(2 + RL));
    endtask

    logic [97:0] k36, k30, k62, krow, k127;

    initial begin
        reset   = 1'b1;
        q_valid = 1'b0;
        q_kmer  = '0;
        r_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            mem1[i] = '0; mem2[i] = '0; mem3[i] = '0; mem4[i] = '0;
        end
        k36 = '0;  k36[36] = 1'b1; k36[97:90] = 8'h11;
        k30 = '0;  k30[30] = 1'b1; k30[97:90] = 8'h22;
        k62 = '0;  k62[15] = 1'b1; k62[25] = 1'b1; k62[31] = 1'b1; k62[50] = 1'b1; k62[97:90] = 8'h33;
        krow = '0; krow[5] = 1'b1; krow[72] = 1'b1; krow[85] = 1'b1; krow[97:90] = 8'hFF;
        k127 = '0;
        k127[5] = 1'b1; k127[17] = 1'b1; k127[20] = 1'b1; k127[36] = 1'b1;
        k127[45] = 1'b1; k127[67] = 1'b1; k127[72] = 1'b1; k127[79] = 1'b1; k127[97:90] = 8'h80;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_ready", 64'(q_ready), 64'd1);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_csb_oeb_web", 64'({CSB, OEB, WEB}), 64'd7);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_r_count", 64'(r_count), 64'd0);
        reset = 1'b0;

        // Row 1 all zero: minimum is zero.
        send(k36, 7'd1, 2'd0, 1'b0);
        // Row 0, offsets 2/0/0/16.
        mem1[0] = 64'hC; mem2[0] = 64'h2; mem3[0] = 64'h3; mem4[0] = 64'h3_0000;
        send(k30, 7'd0, 2'd2, 1'b1);
        // Offset 62 on SRAM1, low bits must be ignored.
        wait_ready();
        mem1[0] = 64'h7FFF_FFFF_FFFF_FFFF; mem2[0] = ONES; mem3[0] = ONES; mem4[0] = ONES;
        send(k62, 7'd0, 2'd1, 1'b0);
        // Row 66, saturated counters, unused q_kmer bits set.
        mem1[66] = 64'h3; mem2[66] = 64'h3; mem3[66] = 64'h3; mem4[66] = 64'h300;
        send(krow, 7'd66, 2'd3, 1'b1);
        // Row 127, offsets 0/0/4/10.
        mem1[127] = 64'h2; mem2[127] = 64'h3; mem3[127] = 64'h30; mem4[127] = 64'hC00;
        send(k127, 7'd127, 2'd2, 1'b1);

        // Backpressure with a competing query held on the input.
        wait_ready();
        mem1[1] = ONES; mem2[1] = ONES; mem3[1] = ONES; mem4[1] = ONES;
        r_ready = 1'b0;
        send(k36, 7'd1, 2'd3, 1'b1);
        q_kmer  = k30;
        q_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_r_valid", 64'(r_valid), 64'd1);
            chk("bp_r_count", 64'(r_count), 64'd3);
            chk("bp_r_position", 64'(r_position), 64'h11);
            chk("bp_q_ready", 64'(q_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        q_valid = 1'b0;
        r_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_r_valid", 64'(r_valid), 64'd0);
        chk("bp_release_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("bp_no_accept", 64'(busy), 64'd0);

        // Reset while a result is waiting: result is dropped.
        r_ready = 1'b0;
        send(k36, 7'd1, 2'd3, 1'b1);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_r_valid", 64'(r_valid), 64'd0);
        chk("mid_rst_csb_oeb_web", 64'({CSB, OEB, WEB}), 64'd7);
        chk("mid_rst_q_ready", 64'(q_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_outputs", 64'({r_count, r_solid, r_position, address}), 64'd0);
        reset   = 1'b0;
        r_ready = 1'b1;

        // Recovery after reset; row 0 still holds the offset-62 data.
        send(k30, 7'd0, 2'd3, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
